// File: rtl/hk_anim_pkg.sv
// Shared types and helpers for the knight sprite animation sequencer.
package hk_anim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_JUMP = 2'd2,
        ST_ATK  = 2'd3
    } anim_state_t;

    localparam logic [3:0] STS_IDLE = 4'd0;
    localparam logic [3:0] STS_WALK = 4'd1;
    localparam logic [3:0] STS_JUMP = 4'd2;
    localparam logic [3:0] STS_ATK  = 4'd3;

    // Unknown motion codes fall back to idle.
    function automatic anim_state_t status_to_state(input logic [3:0] s);
        anim_state_t st;
        case (s)
            STS_WALK: st = ST_WALK;
            STS_JUMP: st = ST_JUMP;
            STS_ATK:  st = ST_ATK;
            default:  st = ST_IDLE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/knight_anim_ctrl_counter.sv
// Hold/frame counters for one sprite set; wraps or saturates on the last frame.
module anim_frame_counter #(
    parameter int HOLD_TICKS = 6
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       clear_i,
    input  logic [3:0] nframes_i,
    input  logic       saturate_i,
    output logic [2:0] frame_idx_o,
    output logic       last_done_o
);

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_TICKS - 1);

    logic [3:0] hold_q, hold_d;
    logic [2:0] frame_q, frame_d;
    logic [2:0] last_idx;
    logic       hold_end;

    assign last_idx    = 3'(nframes_i - 4'd1);
    assign hold_end    = (hold_q == HOLD_LAST);
    assign last_done_o = tick_i & hold_end & (frame_q == last_idx);
    assign frame_idx_o = frame_q;

    always_comb begin
        hold_d  = hold_q;
        frame_d = frame_q;
        if (tick_i) begin
            if (clear_i) begin
                hold_d  = '0;
                frame_d = '0;
            end else if (hold_end) begin
                hold_d = '0;
                if (frame_q != last_idx)
                    frame_d = frame_q + 3'd1;
                else if (!saturate_i)
                    frame_d = '0;
            end else begin
                hold_d = hold_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_q  <= '0;
            frame_q <= '0;
        end else begin
            hold_q  <= hold_d;
            frame_q <= frame_d;
        end
    end

endmodule

// File: rtl/knight_anim_ctrl.sv
// Knight sprite animation sequencer: per-video-frame state, frame index and facing.
module knight_anim_ctrl
    import hk_anim_pkg::*;
#(
    parameter int HOLD_TICKS  = 6,
    parameter int IDLE_FRAMES = 2,
    parameter int WALK_FRAMES = 4,
    parameter int JUMP_FRAMES = 3,
    parameter int ATK_FRAMES  = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [3:0] BallStatus,
    input  logic [1:0] dir_key,
    output logic [1:0] sprite_sel,
    output logic [2:0] frame_idx,
    output logic       facing_left,
    output logic       anim_done
);

    logic        frame_clk_q;
    logic        armed_q;
    logic        tick;
    anim_state_t state_q, state_d;
    anim_state_t req;
    logic        facing_q;
    logic        done_q;
    logic        clear;
    logic        last_done;
    logic [3:0]  nframes;

    // armed_q keeps a level held high through reset from counting as an edge.
    assign tick = frame_clk & ~frame_clk_q & armed_q;
    assign req  = status_to_state(BallStatus);

    always_comb begin
        case (state_q)
            ST_WALK: nframes = 4'(WALK_FRAMES);
            ST_JUMP: nframes = 4'(JUMP_FRAMES);
            ST_ATK:  nframes = 4'(ATK_FRAMES);
            default: nframes = 4'(IDLE_FRAMES);
        endcase
    end

    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        if (tick) begin
            if (state_q == ST_ATK) begin
                if (last_done) begin
                    state_d = req;
                    clear   = 1'b1;
                end
            end else if (req != state_q) begin
                state_d = req;
                clear   = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_clk_q <= 1'b0;
            armed_q     <= 1'b0;
            state_q     <= ST_IDLE;
            facing_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            frame_clk_q <= frame_clk;
            armed_q     <= armed_q | ~frame_clk;
            state_q     <= state_d;
            done_q      <= tick & (state_q == ST_ATK) & last_done;
            if (tick && state_q != ST_ATK) begin
                if (dir_key == 2'b10)
                    facing_q <= 1'b1;
                else if (dir_key == 2'b01)
                    facing_q <= 1'b0;
            end
        end
    end

    anim_frame_counter #(
        .HOLD_TICKS (HOLD_TICKS)
    ) u_cnt (
        .clk_i       (Clk),
        .rst_i       (Reset),
        .tick_i      (tick),
        .clear_i     (clear),
        .nframes_i   (nframes),
        .saturate_i  (state_q == ST_JUMP),
        .frame_idx_o (frame_idx),
        .last_done_o (last_done)
    );

    assign sprite_sel  = state_q;
    assign facing_left = facing_q;
    assign anim_done   = done_q;

endmodule

// File: tb/tb_knight_anim_ctrl.sv
// Directed bench for knight_anim_ctrl with hand-computed frame sequences.
module tb_knight_anim_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic [3:0] BallStatus = 4'd0;
    logic [1:0] dir_key = 2'b00;
    logic [1:0] sprite_sel;
    logic [2:0] frame_idx;
    logic       facing_left;
    logic       anim_done;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    logic done_seen;

    knight_anim_ctrl dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .BallStatus  (BallStatus),
        .dir_key     (dir_key),
        .sprite_sel  (sprite_sel),
        .frame_idx   (frame_idx),
        .facing_left (facing_left),
        .anim_done   (anim_done)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) if (anim_done) done_cnt++;

    task automatic do_tick();
        @(negedge Clk) frame_clk = 1'b1;
        @(negedge Clk) begin
            done_seen = anim_done;
            frame_clk = 1'b0;
        end
        @(negedge Clk);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        n_tests++;
        if (sprite_sel !== 2'd0 || frame_idx !== 3'd0 ||
            facing_left !== 1'b0 || anim_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: sel=%0d idx=%0d face=%0d done=%0d want 0/0/0/0",
                     sprite_sel, frame_idx, facing_left, anim_done);
        end
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_idle();
        BallStatus = 4'd0;
        for (int n = 1; n <= 20; n++) begin
            do_tick();
            n_tests++;
            if (sprite_sel !== 2'd0 || frame_idx !== 3'((n / 6) % 2)) begin
                n_fail++;
                $display("FAIL idle t%0d: sel=%0d idx=%0d want 0/%0d",
                         n, sprite_sel, frame_idx, (n / 6) % 2);
            end
        end
    endtask

    task automatic test_walk();
        BallStatus = 4'd1;
        do_tick();
        n_tests++;
        if (sprite_sel !== 2'd1 || frame_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL walk_enter: sel=%0d idx=%0d want 1/0", sprite_sel, frame_idx);
        end
        for (int n = 1; n <= 24; n++) begin
            do_tick();
            n_tests++;
            if (sprite_sel !== 2'd1 || frame_idx !== 3'((n / 6) % 4)) begin
                n_fail++;
                $display("FAIL walk t%0d: sel=%0d idx=%0d want 1/%0d",
                         n, sprite_sel, frame_idx, (n / 6) % 4);
            end
        end
    endtask

    task automatic test_jump();
        int e;
        BallStatus = 4'd2;
        do_tick();
        n_tests++;
        if (sprite_sel !== 2'd2 || frame_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL jump_enter: sel=%0d idx=%0d want 2/0", sprite_sel, frame_idx);
        end
        for (int n = 1; n <= 30; n++) begin
            do_tick();
            e = (n / 6 > 2) ? 2 : n / 6;
            n_tests++;
            if (sprite_sel !== 2'd2 || frame_idx !== 3'(e)) begin
                n_fail++;
                $display("FAIL jump t%0d: sel=%0d idx=%0d want 2/%0d",
                         n, sprite_sel, frame_idx, e);
            end
        end
    endtask

    task automatic test_attack();
        int d0;
        BallStatus = 4'd3;
        do_tick();
        BallStatus = 4'd0;
        d0 = done_cnt;
        n_tests++;
        if (sprite_sel !== 2'd3 || frame_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL atk_enter: sel=%0d idx=%0d want 3/0", sprite_sel, frame_idx);
        end
        for (int n = 1; n <= 23; n++) begin
            if (n == 10) BallStatus = 4'd1;
            if (n == 14) BallStatus = 4'd0;
            do_tick();
            n_tests++;
            if (sprite_sel !== 2'd3 || frame_idx !== 3'(n / 6) || done_seen !== 1'b0) begin
                n_fail++;
                $display("FAIL atk t%0d: sel=%0d idx=%0d done=%0d want 3/%0d/0",
                         n, sprite_sel, frame_idx, done_seen, n / 6);
            end
        end
        do_tick();
        n_tests++;
        if (done_seen !== 1'b1 || done_cnt - d0 !== 1) begin
            n_fail++;
            $display("FAIL atk_done: pulse=%0d count=%0d want 1/1", done_seen, done_cnt - d0);
        end
        n_tests++;
        if (sprite_sel !== 2'd0 || frame_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL atk_exit: sel=%0d idx=%0d want 0/0", sprite_sel, frame_idx);
        end
    endtask

    task automatic test_facing();
        logic [1:0] dirs [4];
        logic       exp_f [4];
        dirs  = '{2'b10, 2'b00, 2'b01, 2'b10};
        exp_f = '{1'b1, 1'b1, 1'b0, 1'b1};
        BallStatus = 4'd0;
        for (int i = 0; i < 4; i++) begin
            dir_key = dirs[i];
            do_tick();
            n_tests++;
            if (facing_left !== exp_f[i]) begin
                n_fail++;
                $display("FAIL facing%0d: got %0d want %0d", i, facing_left, exp_f[i]);
            end
        end
        dir_key = 2'b00;
        BallStatus = 4'd3;
        do_tick();
        dir_key = 2'b01;
        for (int n = 1; n <= 24; n++) do_tick();
        n_tests++;
        if (facing_left !== 1'b1 || done_seen !== 1'b1) begin
            n_fail++;
            $display("FAIL facing_atk: face=%0d done=%0d want 1/1", facing_left, done_seen);
        end
        n_tests++;
        if (sprite_sel !== 2'd3 || frame_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL atk_restart: sel=%0d idx=%0d want 3/0", sprite_sel, frame_idx);
        end
        BallStatus = 4'd0;
        for (int n = 1; n <= 24; n++) do_tick();
        dir_key = 2'b01;
        do_tick();
        n_tests++;
        if (sprite_sel !== 2'd0 || facing_left !== 1'b0) begin
            n_fail++;
            $display("FAIL facing_post: sel=%0d face=%0d want 0/0", sprite_sel, facing_left);
        end
        dir_key = 2'b00;
    endtask

    task automatic test_level_high();
        BallStatus = 4'd1;
        do_tick();
        @(negedge Clk) frame_clk = 1'b1;
        repeat (100) @(negedge Clk);
        frame_clk = 1'b0;
        @(negedge Clk);
        for (int n = 0; n < 4; n++) do_tick();
        n_tests++;
        if (sprite_sel !== 2'd1 || frame_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL level_hold: sel=%0d idx=%0d want 1/0", sprite_sel, frame_idx);
        end
        do_tick();
        n_tests++;
        if (frame_idx !== 3'd1) begin
            n_fail++;
            $display("FAIL level_step: idx=%0d want 1", frame_idx);
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        d0 = done_cnt;
        @(negedge Clk) frame_clk = 1'b1;
        #2 Reset = 1'b1;
        #1;
        n_tests++;
        if (sprite_sel !== 2'd0 || frame_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_async: sel=%0d idx=%0d want 0/0", sprite_sel, frame_idx);
        end
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        repeat (6) @(negedge Clk);
        n_tests++;
        if (sprite_sel !== 2'd0 || frame_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_high_clk: sel=%0d idx=%0d want 0/0", sprite_sel, frame_idx);
        end
        frame_clk = 1'b0;
        @(negedge Clk);
        do_tick();
        n_tests++;
        if (sprite_sel !== 2'd1 || frame_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_rearm: sel=%0d idx=%0d want 1/0", sprite_sel, frame_idx);
        end
        n_tests++;
        if (done_cnt !== d0) begin
            n_fail++;
            $display("FAIL reset_no_done: pulses=%0d want 0", done_cnt - d0);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_walk();
        test_jump();
        test_attack();
        test_facing();
        test_level_high();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
